// File: rtl/ripple_borrow_subtractor.sv
// Registered unsigned ripple-borrow subtractor: diff = a - b - borrow_in (mod 2^WIDTH).
// Define SUB_SATURATE_EN to clamp borrowing results to zero instead of wrapping.
module ripple_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    // Handshake: no backpressure. An operand set is taken at every rising edge
    // where in_valid is high; out_valid is high for exactly the cycle after it.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_zero_next;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_zero;

    assign w_br[0] = borrow_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_d[i]    = a[i] ^ b[i] ^ w_br[i];
        assign w_br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
    end

`ifdef SUB_SATURATE_EN
    assign w_diff_next = w_br[WIDTH] ? '0 : w_d;
`else
    assign w_diff_next = w_d;
`endif

    assign w_zero_next = ~|w_diff_next;

    // Result registers load only on valid input, so idle X operands never reach them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_diff       <= w_diff_next;
                r_borrow_out <= w_br[WIDTH];
                r_zero       <= w_zero_next;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign zero       = r_zero;

endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// Bench for ripple_borrow_subtractor at WIDTH=1 and WIDTH=4 against an arithmetic model.
// Honours SUB_SATURATE_EN when defined at compile time.
module tb_ripple_borrow_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in4_valid, bin4;
    logic [3:0] a4, b4;
    logic       ov4, bo4, z4;
    logic [3:0] d4;

    // WIDTH=1 instance
    logic       in1_valid, bin1;
    logic [0:0] a1, b1;
    logic       ov1, bo1, z1;
    logic [0:0] d1;

    ripple_borrow_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in4_valid), .a(a4), .b(b4), .borrow_in(bin4),
        .out_valid(ov4), .diff(d4), .borrow_out(bo4), .zero(z4)
    );

    ripple_borrow_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in1_valid), .a(a1), .b(b1), .borrow_in(bin1),
        .out_valid(ov1), .diff(d1), .borrow_out(bo1), .zero(z1)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: widened arithmetic, expected register contents per instance.
    logic       m4_v, m4_bo, m4_z;
    logic [3:0] m4_d;
    logic       m1_v, m1_bo, m1_z;
    logic [0:0] m1_d;

    always @(posedge clk) begin
        logic [4:0] full4;
        logic [1:0] full1;
        if (rst) begin
            m4_v = 0; m4_d = 0; m4_bo = 0; m4_z = 0;
            m1_v = 0; m1_d = 0; m1_bo = 0; m1_z = 0;
        end else begin
            m4_v = in4_valid;
            if (in4_valid) begin
                full4 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
                m4_bo = ({1'b0, a4} < ({1'b0, b4} + {4'b0, bin4}));
                m4_d  = full4[3:0];
`ifdef SUB_SATURATE_EN
                if (m4_bo) m4_d = 0;
`endif
                m4_z = (m4_d == 0);
            end
            m1_v = in1_valid;
            if (in1_valid) begin
                full1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
                m1_bo = ({1'b0, a1} < ({1'b0, b1} + {1'b0, bin1}));
                m1_d  = full1[0:0];
`ifdef SUB_SATURATE_EN
                if (m1_bo) m1_d = 0;
`endif
                m1_z = (m1_d == 0);
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("w4_out_valid", ov4, m4_v);
            check("w4_diff",      d4,  m4_d);
            check("w4_borrow",    bo4, m4_bo);
            check("w4_zero",      z4,  m4_z);
            check("w1_out_valid", ov1, m1_v);
            check("w1_diff",      d1,  m1_d);
            check("w1_borrow",    bo1, m1_bo);
            check("w1_zero",      z1,  m1_z);
        end
    end

    task automatic op4(input logic v, input logic [3:0] x, input logic [3:0] y, input logic bi);
        in4_valid = v; a4 = x; b4 = y; bin4 = bi;
        in1_valid = 0; a1 = 'x; b1 = 'x; bin1 = 'x;
        @(negedge clk);
    endtask

    task automatic op1(input logic v, input logic x, input logic y, input logic bi);
        in1_valid = v; a1 = x; b1 = y; bin1 = bi;
        in4_valid = 0; a4 = 'x; b4 = 'x; bin4 = 'x;
        @(negedge clk);
    endtask

    // Literal expectation for a wrap-mode result, adjusted for saturation when enabled.
    task automatic pin4(input string name, input logic [3:0] ed, input logic ebo);
        logic [3:0] d;
        d = ed;
`ifdef SUB_SATURATE_EN
        if (ebo) d = 0;
`endif
        check({name, "_valid"},  ov4, 1'b1);
        check({name, "_diff"},   d4,  d);
        check({name, "_borrow"}, bo4, ebo);
        check({name, "_zero"},   z4,  (d == 0));
    endtask

    logic [7:0] tt_d  = 8'b1001_0110; // index {a,b,bin}
    logic [7:0] tt_bo = 8'b1000_1110;

    initial begin
        rst = 1'b1;
        in4_valid = 0; a4 = 0; b4 = 0; bin4 = 0;
        in1_valid = 0; a1 = 0; b1 = 0; bin1 = 0;
        @(negedge clk);
        op4(1'b0, 4'd0, 4'd0, 1'b0);
        chk_en = 1'b1;
        check("reset_valid",  ov4, 1'b0);
        check("reset_diff",   d4,  4'd0);
        check("reset_borrow", bo4, 1'b0);
        check("reset_zero",   z4,  1'b0);
        rst = 1'b0;

        // WIDTH=1 full-subtractor truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            logic       ed;
            abc = 3'(i);
            op1(1'b1, abc[2], abc[1], abc[0]);
            ed = tt_d[i];
`ifdef SUB_SATURATE_EN
            if (tt_bo[i]) ed = 1'b0;
`endif
            check($sformatf("tt%0b_valid", abc), ov1, 1'b1);
            check($sformatf("tt%0b_diff", abc), d1, ed);
            check($sformatf("tt%0b_borrow", abc), bo1, tt_bo[i]);
        end

        // WIDTH=4 basic and full-ripple ops
        op4(1'b1, 4'd5,  4'd3,  1'b0); pin4("5m3",      4'd2,  1'b0);
        op4(1'b1, 4'd3,  4'd5,  1'b0); pin4("3m5",      4'd14, 1'b1);
        op4(1'b1, 4'd9,  4'd9,  1'b0); pin4("9m9",      4'd0,  1'b0);
        op4(1'b1, 4'd0,  4'd0,  1'b1); pin4("0m0b",     4'd15, 1'b1);
        op4(1'b1, 4'd15, 4'd15, 1'b1); pin4("15m15b",   4'd15, 1'b1);
        op4(1'b1, 4'd8,  4'd0,  1'b1); pin4("8m0b",     4'd7,  1'b0);

`ifdef SUB_SATURATE_EN
        op4(1'b1, 4'd3, 4'd5, 1'b0);
        check("sat_diff", d4, 4'd0); check("sat_borrow", bo4, 1'b1); check("sat_zero", z4, 1'b1);
        op4(1'b1, 4'd5, 4'd3, 1'b0);
        check("sat_nb_diff", d4, 4'd2);
`endif

        // Valid handling: one issue then idle with X operands
        op4(1'b1, 4'd6, 4'd1, 1'b0);
        check("hold_issue_valid", ov4, 1'b1);
        check("hold_issue_diff",  d4,  4'd5);
        for (int k = 0; k < 3; k++) begin
            op4(1'b0, 4'bx, 4'bx, 1'bx);
            check($sformatf("hold%0d_valid", k), ov4, 1'b0);
            check($sformatf("hold%0d_diff", k),  d4,  4'd5);
        end

        // Reset beats in_valid on the same edge
        rst = 1'b1;
        op4(1'b1, 4'd7, 4'd2, 1'b0);
        rst = 1'b0;
        check("rst_valid",  ov4, 1'b0);
        check("rst_diff",   d4,  4'd0);
        check("rst_borrow", bo4, 1'b0);
        check("rst_zero",   z4,  1'b0);
        op4(1'b1, 4'd7, 4'd2, 1'b0);
        check("post_rst_valid", ov4, 1'b1);
        check("post_rst_diff",  d4,  4'd5);

        // Randomized traffic on both instances, idle operands as X, rare resets
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            in4_valid = ($urandom_range(0, 3) != 0);
            in1_valid = ($urandom_range(0, 3) != 0);
            if (in4_valid) begin
                a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
            end else begin
                a4 = 'x; b4 = 'x; bin4 = 'x;
            end
            if (in1_valid) begin
                a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            end else begin
                a1 = 'x; b1 = 'x; bin1 = 'x;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        in4_valid = 0; in1_valid = 0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
